// File: rtl/button_debouncer_pkg.sv
// Shared types and defaults for the button debouncer: FSM state encoding and
// default timing parameters.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam int DEFAULT_CLOCK_FREQUENCY = 100_000_000;
  localparam int DEFAULT_STABLE_CYCLES   = 1_000_000;
  localparam int DEFAULT_SYNC_STAGES     = 2;

endpackage

// File: rtl/button_debouncer_if.sv
// Raw button input and debounced outputs.
// Outputs are registered levels/strobes with no handshake: they are sampled on
// every clk edge, and o_w_rise/o_w_fall are valid for exactly one cycle each.
interface button_debouncer_if;

  logic i_w_in;
  logic o_w_level;
  logic o_w_rise;
  logic o_w_fall;
  logic o_w_busy;

  modport master (
    output i_w_in,
    input  o_w_level,
    input  o_w_rise,
    input  o_w_fall,
    input  o_w_busy
  );

  modport slave (
    input  i_w_in,
    output o_w_level,
    output o_w_rise,
    output o_w_fall,
    output o_w_busy
  );

endinterface

// File: rtl/button_debouncer_sync_ff.sv
// N-stage flip-flop synchronizer with synchronous reset, used wherever an
// asynchronous board input enters the clk domain.
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic i_w_reset,
  input  logic i_w_d,
  output logic o_w_q
);

  logic [N-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (i_w_reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[N-2:0], i_w_d};
    end
  end

  assign o_w_q = r_chain[N-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a bouncing asynchronous input: synchronizer, stability counter and
// a four-state FSM producing a clean level plus one-cycle rise/fall strobes.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = DEFAULT_CLOCK_FREQUENCY,
  parameter int STABLE_CYCLES   = DEFAULT_STABLE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                i_w_reset,
  button_debouncer_if.slave   bus,
  output state_t              o_state
);

  localparam int            CW   = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2 || SYNC_STAGES < 2 || CLOCK_FREQUENCY <= 0) begin : g_bad_params
    $error("button_debouncer: STABLE_CYCLES and SYNC_STAGES must be >= 2");
  end

  logic          w_sync_in;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic          r_busy;

  sync_ff #(
    .N(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .i_w_reset(i_w_reset),
    .i_w_d    (bus.i_w_in),
    .o_w_q    (w_sync_in)
  );

  // A candidate accumulates one sample per cycle; a single disagreeing sample
  // aborts it, and the abort check comes before the commit check.
  always_ff @(posedge clk) begin
    if (i_w_reset) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        IDLE_LOW: begin
          r_cnt <= '0;
          if (w_sync_in) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= CW'(1);
            r_busy  <= 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (!w_sync_in) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == LAST) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_rise  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        IDLE_HIGH: begin
          r_cnt <= '0;
          if (!w_sync_in) begin
            r_state <= WAIT_LOW;
            r_cnt   <= CW'(1);
            r_busy  <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (w_sync_in) begin
            r_state <= IDLE_HIGH;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == LAST) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE_LOW;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_w_level = r_level;
  assign bus.o_w_rise  = r_rise;
  assign bus.o_w_fall  = r_fall;
  assign bus.o_w_busy  = r_busy;
  assign o_state       = r_state;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=8, SYNC_STAGES=2.
// Relative cycle k=0 is the cycle in which the input edge is driven.
module tb_button_debouncer;
  import button_debouncer_pkg::*;

  logic   clk;
  logic   rst;
  state_t state;
  int     checks;
  int     errors;

  button_debouncer_if bus ();

  button_debouncer #(
    .CLOCK_FREQUENCY(100_000_000),
    .STABLE_CYCLES  (8),
    .SYNC_STAGES    (2)
  ) dut (
    .clk      (clk),
    .i_w_reset(rst),
    .bus      (bus),
    .o_state  (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_w_in = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if ({bus.o_w_level, bus.o_w_rise, bus.o_w_fall, bus.o_w_busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b%b%b%b exp 0000", bus.o_w_level, bus.o_w_rise,
               bus.o_w_fall, bus.o_w_busy);
    end
    checks++;
    if (state !== IDLE_LOW) begin
      errors++;
      $display("FAIL reset_state got %0d exp %0d", state, IDLE_LOW);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({bus.o_w_level, bus.o_w_rise, bus.o_w_fall, bus.o_w_busy} !== 4'b0000) begin
        errors++;
        $display("FAIL post_reset_idle cyc=%0d got %b%b%b%b exp 0000", i, bus.o_w_level,
                 bus.o_w_rise, bus.o_w_fall, bus.o_w_busy);
      end
    end
  endtask

  task automatic test_clean_press();
    step();
    bus.i_w_in = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      checks++;
      if (bus.o_w_rise !== (k == 10)) begin
        errors++;
        $display("FAIL press_rise k=%0d got %b exp %b", k, bus.o_w_rise, (k == 10));
      end
      checks++;
      if (bus.o_w_level !== (k >= 10)) begin
        errors++;
        $display("FAIL press_level k=%0d got %b exp %b", k, bus.o_w_level, (k >= 10));
      end
      checks++;
      if (bus.o_w_busy !== (k >= 3 && k <= 9)) begin
        errors++;
        $display("FAIL press_busy k=%0d got %b exp %b", k, bus.o_w_busy, (k >= 3 && k <= 9));
      end
      checks++;
      if (bus.o_w_fall !== 1'b0) begin
        errors++;
        $display("FAIL press_fall k=%0d got %b exp 0", k, bus.o_w_fall);
      end
    end
  endtask

  task automatic test_release();
    step();
    bus.i_w_in = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++;
      if (bus.o_w_fall !== (k == 10)) begin
        errors++;
        $display("FAIL release_fall k=%0d got %b exp %b", k, bus.o_w_fall, (k == 10));
      end
      checks++;
      if (bus.o_w_level !== (k < 10)) begin
        errors++;
        $display("FAIL release_level k=%0d got %b exp %b", k, bus.o_w_level, (k < 10));
      end
      checks++;
      if (bus.o_w_busy !== (k >= 3 && k <= 9)) begin
        errors++;
        $display("FAIL release_busy k=%0d got %b exp %b", k, bus.o_w_busy, (k >= 3 && k <= 9));
      end
      checks++;
      if (bus.o_w_rise !== 1'b0) begin
        errors++;
        $display("FAIL release_rise k=%0d got %b exp 0", k, bus.o_w_rise);
      end
    end
  endtask

  task automatic test_bounce();
    // high 3, low 1, high 2, low 1, high 5, low 1
    logic [12:0] pattern;
    pattern = 13'b1110110111110;
    for (int i = 12; i >= 0; i--) begin
      step();
      bus.i_w_in = pattern[i];
      checks++;
      if ({bus.o_w_level, bus.o_w_rise, bus.o_w_fall} !== 3'b000) begin
        errors++;
        $display("FAIL bounce_quiet i=%0d got %b%b%b exp 000", i, bus.o_w_level, bus.o_w_rise,
                 bus.o_w_fall);
      end
    end
    step();
    bus.i_w_in = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      checks++;
      if (bus.o_w_rise !== (k == 10)) begin
        errors++;
        $display("FAIL bounce_rise k=%0d got %b exp %b", k, bus.o_w_rise, (k == 10));
      end
      checks++;
      if (bus.o_w_level !== (k >= 10)) begin
        errors++;
        $display("FAIL bounce_level k=%0d got %b exp %b", k, bus.o_w_level, (k >= 10));
      end
    end
  endtask

  task automatic test_glitch_threshold();
    step();
    bus.i_w_in = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 7) bus.i_w_in = 1'b0;
      checks++;
      if ({bus.o_w_level, bus.o_w_rise, bus.o_w_fall} !== 3'b000) begin
        errors++;
        $display("FAIL glitch_quiet k=%0d got %b%b%b exp 000", k, bus.o_w_level, bus.o_w_rise,
                 bus.o_w_fall);
      end
      checks++;
      if (bus.o_w_busy !== (k >= 3 && k <= 9)) begin
        errors++;
        $display("FAIL glitch_busy k=%0d got %b exp %b", k, bus.o_w_busy, (k >= 3 && k <= 9));
      end
    end
    checks++;
    if (state !== IDLE_LOW) begin
      errors++;
      $display("FAIL glitch_state got %0d exp %0d", state, IDLE_LOW);
    end
  endtask

  task automatic test_reset_mid_qual();
    step();
    bus.i_w_in = 1'b1;
    for (int k = 1; k <= 7; k++) step();
    checks++;
    if (bus.o_w_busy !== 1'b1 || state !== WAIT_HIGH) begin
      errors++;
      $display("FAIL midq_pending got busy=%b state=%0d exp busy=1 state=%0d", bus.o_w_busy,
               state, WAIT_HIGH);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.o_w_level, bus.o_w_rise, bus.o_w_fall, bus.o_w_busy} !== 4'b0000
        || state !== IDLE_LOW) begin
      errors++;
      $display("FAIL midq_reset got %b%b%b%b state=%0d exp 0000 state=0", bus.o_w_level,
               bus.o_w_rise, bus.o_w_fall, bus.o_w_busy, state);
    end
    for (int j = 1; j <= 13; j++) begin
      step();
      checks++;
      if (bus.o_w_rise !== (j == 10)) begin
        errors++;
        $display("FAIL midq_rise j=%0d got %b exp %b", j, bus.o_w_rise, (j == 10));
      end
      checks++;
      if (bus.o_w_level !== (j >= 10)) begin
        errors++;
        $display("FAIL midq_level j=%0d got %b exp %b", j, bus.o_w_level, (j >= 10));
      end
      checks++;
      if (bus.o_w_busy !== (j >= 3 && j <= 9)) begin
        errors++;
        $display("FAIL midq_busy j=%0d got %b exp %b", j, bus.o_w_busy, (j >= 3 && j <= 9));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.i_w_in = 1'b0;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_release();
    test_glitch_threshold();
    test_reset_mid_qual();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
